// File: rtl/axis_fifo_pkt.sv
// axis_fifo_pkt: AXI-Stream FIFO with TLAST framing, any-depth storage, occupancy/packet counts,
// almost-full/almost-empty flags and an optional store-and-forward packet mode.
module axis_fifo_pkt #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 40,
    parameter int AFULL_TH    = DEPTH - 2,
    parameter int AEMPTY_TH   = 2,
    parameter int PACKET_MODE = 0,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_tvalid,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic                  m_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic [CW-1:0]         count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         pkt_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic                full, empty, wr_en, rd_en, wr_last, rd_last;

    assign full         = count == CW'(DEPTH);
    assign empty        = count == '0;
    assign s_tready     = !full;
    // In packet mode a full FIFO releases its head so oversize packets cannot deadlock
    assign m_tvalid     = !empty && (PACKET_MODE == 0 || pkt_count != '0 || full);
    assign wr_en        = s_tvalid && s_tready;
    assign rd_en        = m_tvalid && m_tready;
    assign wr_last      = wr_en && s_tlast;
    assign rd_last      = rd_en && m_tlast;
    assign {m_tlast, m_tdata} = mem[rd_ptr];
    assign almost_full  = int'(count) >= AFULL_TH;
    assign almost_empty = int'(count) <= AEMPTY_TH;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {s_tlast, s_tdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pkt_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(rd_en);
            if (!(wr_last && !rd_last && pkt_count == CW'(DEPTH)))
                pkt_count <= pkt_count + CW'(wr_last) - CW'(rd_last);
        end
    end
endmodule

// File: tb/tb_axis_fifo_pkt.sv
// tb_axis_fifo_pkt: randomized bench for three axis_fifo_pkt configurations checked against a queue model.
module tb_axis_fifo_pkt;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic       tv = 0, tl = 0, tr = 0;
    logic [7:0] td = 0;
    int         sel = 0;
    int         errors = 0, checks = 0;

    logic [2:0] sr, mv, ml, af, ae;
    logic [7:0] md0, md1, md2;
    logic [2:0] c0, p0, c1, p1;
    logic [3:0] c2, p2;

    axis_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(5), .AFULL_TH(3), .AEMPTY_TH(2), .PACKET_MODE(0)) u_s5 (
        .clk(clk), .rst(rst), .s_tvalid(tv && sel == 0), .s_tdata(td), .s_tlast(tl), .s_tready(sr[0]),
        .m_tvalid(mv[0]), .m_tdata(md0), .m_tlast(ml[0]), .m_tready(tr && sel == 0),
        .count(c0), .almost_full(af[0]), .almost_empty(ae[0]), .pkt_count(p0));
    axis_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_TH(2), .AEMPTY_TH(2), .PACKET_MODE(1)) u_p4 (
        .clk(clk), .rst(rst), .s_tvalid(tv && sel == 1), .s_tdata(td), .s_tlast(tl), .s_tready(sr[1]),
        .m_tvalid(mv[1]), .m_tdata(md1), .m_tlast(ml[1]), .m_tready(tr && sel == 1),
        .count(c1), .almost_full(af[1]), .almost_empty(ae[1]), .pkt_count(p1));
    axis_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .PACKET_MODE(1)) u_p8 (
        .clk(clk), .rst(rst), .s_tvalid(tv && sel == 2), .s_tdata(td), .s_tlast(tl), .s_tready(sr[2]),
        .m_tvalid(mv[2]), .m_tdata(md2), .m_tlast(ml[2]), .m_tready(tr && sel == 2),
        .count(c2), .almost_full(af[2]), .almost_empty(ae[2]), .pkt_count(p2));

    logic [3:0] o_count, o_pk;
    logic [7:0] o_md;
    always_comb begin
        o_count = sel == 0 ? 4'(c0) : sel == 1 ? 4'(c1) : c2;
        o_pk    = sel == 0 ? 4'(p0) : sel == 1 ? 4'(p1) : p2;
        o_md    = sel == 0 ? md0 : sel == 1 ? md1 : md2;
    end

    // Reference model: FIFO contents as a queue of {tlast, tdata}
    logic [8:0] q[$];
    int dep = 5, pm = 0, aft = 3, aet = 2;

    function automatic int npk();
        int k = 0;
        foreach (q[i]) if (q[i][8]) k++;
        return k;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (dut %0d, t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r,
                        output logic wf, output logic rf);
        int n, pk;
        logic full, ev;
        tv = v; td = d; tl = l; tr = r;
        #1;
        n    = q.size();
        pk   = npk();
        full = n == dep;
        ev   = n > 0 && (pm == 0 || pk > 0 || full);
        chk("count", int'(o_count), n);
        chk("pkt_count", int'(o_pk), pk);
        chk("s_tready", int'(sr[sel]), int'(!full));
        chk("m_tvalid", int'(mv[sel]), int'(ev));
        chk("almost_full", int'(af[sel]), int'(n >= aft));
        chk("almost_empty", int'(ae[sel]), int'(n <= aet));
        if (ev) begin
            chk("m_tdata", int'(o_md), int'(q[0][7:0]));
            chk("m_tlast", int'(ml[sel]), int'(q[0][8]));
        end
        wf = v && !full;
        rf = ev && r;
        @(posedge clk);
        if (rf) void'(q.pop_front());
        if (wf) q.push_back({l, d});
        @(negedge clk);
    endtask

    // lastpos>0: tlast every lastpos beats; 0: never; <0: pseudo-random with tlast forced on the final beat
    task automatic run(input int nbeats, input int base, input int lastpos, input int pv, input int pr,
                       input int maxcyc, input bit drain);
        int w = 0, cyc = 0;
        logic wf, rf, l, v, r;
        while ((w < nbeats || (drain && q.size() > 0)) && cyc < maxcyc) begin
            v = w < nbeats && ($urandom_range(99) < pv);
            r = $urandom_range(99) < pr;
            l = lastpos > 0 ? ((w + 1) % lastpos == 0) :
                lastpos < 0 ? (w == nbeats - 1 || $urandom_range(3) == 0) : 1'b0;
            step(v, 8'(base + w), l, r, wf, rf);
            if (wf) w++;
            cyc++;
        end
        chk("beats_written", w, nbeats);
        if (drain) chk("drained", q.size(), 0);
    endtask

    task automatic do_reset();
        tv = 0; tr = 0;
        rst = 1;
        #1;
        q.delete();
        chk("rst_count", int'(o_count), 0);
        chk("rst_pkt_count", int'(o_pk), 0);
        chk("rst_m_tvalid", int'(mv[sel]), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic use_dut(input int s);
        do_reset();
        sel = s;
        dep = s == 0 ? 5 : s == 1 ? 4 : 8;
        pm  = s == 0 ? 0 : 1;
        aft = dep - 2;
        aet = 2;
    endtask

    initial begin
        logic wf, rf;
        repeat (2) @(negedge clk);
        rst = 0;
        step(0, 0, 0, 0, wf, rf);
        // stream DEPTH=5: fill to full, then drain
        run(5, 8'hA0, 0, 100, 0, 20, 0);
        step(0, 0, 0, 0, wf, rf);
        run(0, 0, 0, 0, 100, 20, 1);
        // wrap-around with random interleave
        run(12, 0, 0, 50, 50, 300, 1);
        // simultaneous read/write at count=3
        run(3, 8'h10, 0, 100, 0, 20, 0);
        run(10, 8'h20, 0, 100, 100, 10, 0);
        run(0, 0, 0, 0, 100, 20, 1);
        run(60, 8'h80, -1, 60, 60, 600, 1);
        // mid-stream reset with count=4, then a fresh beat
        run(4, 8'h40, 0, 100, 0, 20, 0);
        do_reset();
        step(0, 0, 0, 0, wf, rf);
        run(1, 8'h55, 0, 100, 100, 20, 1);
        // packet mode DEPTH=8: 3-beat packet held until tlast
        use_dut(2);
        run(3, 8'h30, 3, 100, 100, 50, 1);
        run(40, 8'h60, -1, 60, 60, 600, 1);
        // packet mode DEPTH=4: 6-beat packet forces release on full
        use_dut(1);
        run(6, 8'hC0, 6, 100, 100, 60, 1);
        run(40, 8'hD0, -1, 70, 50, 600, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axis_fifo_pkt.md
Name: axis_fifo_pkt

Overview:
Parametrised successor to the single-channel AXI-Stream FIFO. It adds TLAST framing, full-depth storage at any DEPTH (power of two not required), an occupancy count, and programmable almost-full/almost-empty flags. An optional packet mode holds off the output until a complete frame is buffered. It sits between AXI-Stream producers and consumers on the same clock.

Parameters:
DATA_WIDTH, 32, tdata width in bits (>=1)
DEPTH, 40, number of storage entries, any integer >=2; all DEPTH entries usable
AFULL_TH, DEPTH-2, almost_full asserted when count >= AFULL_TH
AEMPTY_TH, 2, almost_empty asserted when count <= AEMPTY_TH
PACKET_MODE, 0, 0 = stream mode; 1 = output gated until a complete packet is stored
CW, $clog2(DEPTH+1), derived width of the count output

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
s_tvalid  input  1  write-side valid
s_tdata  input  DATA_WIDTH  write-side data
s_tlast  input  1  write-side end of packet
s_tready  output  1  write-side ready
m_tvalid  output  1  read-side valid
m_tdata  output  DATA_WIDTH  read-side data
m_tlast  output  1  read-side end of packet
m_tready  input  1  read-side ready
count  output  CW  current occupancy, 0..DEPTH
almost_full  output  1  count >= AFULL_TH
almost_empty  output  1  count <= AEMPTY_TH
pkt_count  output  CW  number of complete packets (stored tlast=1 beats) currently held

Behaviour:
- Reset (async, active-high) applies immediately, mid-transfer included. Pointers, count and pkt_count go to 0. s_tready=1 once rst deasserts, m_tvalid=0, almost_empty=1, almost_full=0. Memory contents are not reset. m_tdata and m_tlast are don't-care while m_tvalid=0.
- Storage is a memory of DEPTH x (DATA_WIDTH+1), holding tdata and tlast.
- wr_ptr and rd_ptr each run 0..DEPTH-1 and wrap explicitly from DEPTH-1 to 0. Implicit binary overflow is not relied on.
- Full and empty are derived from count, not from pointer comparison. full = (count==DEPTH); empty = (count==0).
- s_tready = !full, a registered-flag function with no combinational path from s_tvalid or m_tready.
- Write fires when s_tvalid && s_tready. The beat is stored at wr_ptr and wr_ptr advances.
- First-word fall-through: m_tdata and m_tlast present the entry at rd_ptr combinationally from memory and state.
- Stream mode: m_tvalid = !empty.
- Packet mode: m_tvalid = !empty && (pkt_count != 0 || full).
  - The "|| full" term prevents deadlock on packets longer than DEPTH.
- Read fires when m_tvalid && m_tready. rd_ptr advances.
- Latency: a beat written at edge N is visible on m_tvalid after edge N (1 cycle) in stream mode.
- Simultaneous read and write in the same cycle: count is unchanged and both pointers advance.
- When full, a read frees a slot; s_tready rises the next cycle. There is no same-cycle pass-through.
- When empty, a write cannot be read in the same cycle.
- count: +1 on write only, -1 on read only, unchanged on both or neither. It never exceeds DEPTH or goes below 0.
- pkt_count: +1 when a written beat has tlast=1, -1 when a read beat has tlast=1. Both in the same cycle leaves it unchanged. It saturates logically at DEPTH.
- AXI rules:
  - m_tvalid, once high, stays high and m_tdata/m_tlast stay stable until the beat is accepted.
  - A packet-mode exception: m_tvalid can only rise, never drop, while the head is held.
  - Upstream s_tdata is sampled only on a write fire.
- almost_full and almost_empty are combinational from the registered count and update in the cycle after the causing edge.

Test Plan:
- DEPTH=5 stream mode: write 5 beats 0xA0..0xA4 with m_tready=0 -> s_tready=0 after the 5th, count=5, almost_full=1. Then read all 5 -> data 0xA0..0xA4 in order, count=0, m_tvalid=0.
- Wrap-around, DEPTH=5: 12 beats 0..11 with write and read interleaved at random -> output sequence 0..11 with no loss and no duplication; pointers pass index 4->0 at least twice.
- Simultaneous read and write with count=3 held for 10 cycles, m_tready=1 and s_tvalid=1 -> count stays 3 and data order is preserved.
- PACKET_MODE=1, DEPTH=8: write 3 beats with tlast only on the 3rd -> m_tvalid=0 after beats 1-2 and 1 the cycle after beat 3; pkt_count goes 0->1->0 after the read-out.
- PACKET_MODE=1, DEPTH=4: write a 6-beat packet -> on full, m_tvalid=1 and draining proceeds; all 6 beats are delivered with m_tlast only on the 6th.
- Assert rst for 1 cycle mid-stream with count=4 -> count=0, pkt_count=0, m_tvalid=0 immediately. A post-reset write of 0x55 is read back as 0x55.
